// File: rtl/hex_count_pkg.sv
// Shared types and key index constants for the hex counter controller.
package hex_count_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    localparam int unsigned KEY_FASTER = 0;
    localparam int unsigned KEY_SLOWER = 1;
    localparam int unsigned KEY_RUN    = 2;
    localparam int unsigned KEY_DIR    = 3;

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchronizer, level debouncer and a release pulse
// that fires the cycle after the debounced level falls.
module key_debouncer #(
    parameter int unsigned debounce_cycles = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic rel
);

    localparam int unsigned CW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(debounce_cycles - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            rel     <= 1'b0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_d <= level;
            rel     <= level_d & ~level;
            // Count consecutive samples that disagree with the accepted level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_count_controller.sv
// Key-controlled up/down counter with an adjustable tick period and run/pause.
module hex_count_controller
    import hex_count_pkg::*;
#(
    parameter int unsigned clk_mhz         = 50,
    parameter int unsigned w_key           = 4,
    parameter int unsigned w_cnt           = 32,
    parameter int unsigned min_period      = clk_mhz * 1000 * 1000 / 50,
    parameter int unsigned max_period      = clk_mhz * 1000 * 1000 * 3,
    parameter int unsigned init_period     = clk_mhz * 1000 * 1000,
    parameter int unsigned debounce_cycles = clk_mhz * 1000 * 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_key-1:0] key,
    output logic             tick,
    output logic [w_cnt-1:0] count,
    output logic [31:0]      period,
    output logic             running,
    output logic             dir_down
);

    logic [w_key-1:0] rel;
    state_t           state;
    state_t           state_n;
    logic [31:0]      div;
    logic [31:0]      period_n;
    logic             period_chg;
    logic [32:0]      dbl;
    logic [32:0]      half;

    for (genvar i = 0; i < w_key; i++) begin : g_key
        key_debouncer #(
            .debounce_cycles(debounce_cycles)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .key  (key[i]),
            .rel  (rel[i])
        );
    end

    logic faster_ev;
    logic slower_ev;
    logic run_ev;
    logic dir_ev;

    assign faster_ev = rel[KEY_FASTER];
    assign slower_ev = rel[KEY_SLOWER];
    assign run_ev    = rel[KEY_RUN];
    assign dir_ev    = rel[KEY_DIR];

    // Next state and saturating period arithmetic in 33 bits.
    always_comb begin
        state_n    = state;
        period_n   = period;
        period_chg = 1'b0;
        dbl        = {period, 1'b0};
        half       = {2'b00, period[31:1]};

        if (run_ev) begin
            state_n = (state == RUN) ? PAUSE : RUN;
        end

        if (faster_ev && !slower_ev) begin
            period_chg = 1'b1;
            period_n   = (half < 33'(min_period)) ? 32'(min_period) : half[31:0];
        end else if (slower_ev && !faster_ev) begin
            period_chg = 1'b1;
            period_n   = (dbl > 33'(max_period)) ? 32'(max_period) : dbl[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            running  <= 1'b1;
            dir_down <= 1'b0;
            period   <= 32'(init_period);
            div      <= 32'(init_period - 1);
            tick     <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_n;
            running  <= (state_n == RUN);
            dir_down <= dir_down ^ dir_ev;
            period   <= period_n;
            tick     <= 1'b0;
            // A period change restarts the phase; pause parks the divider.
            if (period_chg) begin
                div <= period_n - 32'd1;
            end else if (state == PAUSE) begin
                div <= period - 32'd1;
            end else if (div == 32'd0) begin
                div   <= period - 32'd1;
                tick  <= 1'b1;
                count <= dir_down ? count - w_cnt'(1) : count + w_cnt'(1);
            end else begin
                div <= div - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hex_count_controller.sv
// Directed bench for hex_count_controller with small periods and debounce.
module tb_hex_count_controller;

    localparam int unsigned W_CNT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       key;
    logic             tick;
    logic [W_CNT-1:0] count;
    logic [31:0]      period;
    logic             running;
    logic             dir_down;

    int n_cmp  = 0;
    int n_fail = 0;

    hex_count_controller #(
        .clk_mhz        (50),
        .w_key          (4),
        .w_cnt          (W_CNT),
        .min_period     (4),
        .max_period     (64),
        .init_period    (16),
        .debounce_cycles(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key     (key),
        .tick    (tick),
        .count   (count),
        .period  (period),
        .running (running),
        .dir_down(dir_down)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [31:0] exp_period;
        logic        exp_running;
        logic        exp_dir;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] mask, input int hold);
        key = key | mask;
        cycles(hold);
        key = key & ~mask;
    endtask

    task automatic press_release(input logic [3:0] mask);
        tap(mask, 6);
        cycles(12);
    endtask

    task automatic wait_tick(input string name, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < budget);
        if (!tick) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no tick within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_running(input string name, input logic val, input int budget);
        int n;
        n = 0;
        while (running !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(running), 32'(val));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key   = '0;
        cycles(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [W_CNT-1:0] held;
        int ticks;

        vecs[0]  = '{"slow_32",   4'b0010, 32, 1'b1, 1'b0};
        vecs[1]  = '{"slow_64",   4'b0010, 64, 1'b1, 1'b0};
        vecs[2]  = '{"slow_sat",  4'b0010, 64, 1'b1, 1'b0};
        vecs[3]  = '{"fast_32",   4'b0001, 32, 1'b1, 1'b0};
        vecs[4]  = '{"fast_16",   4'b0001, 16, 1'b1, 1'b0};
        vecs[5]  = '{"fast_8",    4'b0001,  8, 1'b1, 1'b0};
        vecs[6]  = '{"fast_4",    4'b0001,  4, 1'b1, 1'b0};
        vecs[7]  = '{"fast_sat",  4'b0001,  4, 1'b1, 1'b0};
        vecs[8]  = '{"slow_8",    4'b0010,  8, 1'b1, 1'b0};
        vecs[9]  = '{"both_keys", 4'b0011,  8, 1'b1, 1'b0};
        vecs[10] = '{"dir_down",  4'b1000,  8, 1'b1, 1'b1};
        vecs[11] = '{"pause",     4'b0100,  8, 1'b0, 1'b1};
        vecs[12] = '{"resume",    4'b0100,  8, 1'b1, 1'b1};
        vecs[13] = '{"dir_up",    4'b1000,  8, 1'b1, 1'b0};

        // Reset values while held in reset.
        rst_n = 1'b0;
        key   = '0;
        cycles(2);
        check("rst_count",   32'(count), 0);
        check("rst_period",  period, 16);
        check("rst_running", 32'(running), 1);
        check("rst_dir",     32'(dir_down), 0);
        check("rst_tick",    32'(tick), 0);

        rst_n = 1'b1;
        wait_tick("first_tick", 40, n);
        check("first_tick_latency", 32'(n), 16);
        check("first_tick_count",   32'(count), 1);

        // Down-wrap from zero, then up-wrap from 0xFF.
        do_reset();
        tap(4'b1000, 5);
        wait_tick("wrap_down_tick", 40, n);
        check("wrap_down_dir",   32'(dir_down), 1);
        check("wrap_down_count", 32'(count), 32'hFF);
        tap(4'b1000, 5);
        wait_tick("wrap_up_tick", 40, n);
        check("wrap_up_dir",   32'(dir_down), 0);
        check("wrap_up_count", 32'(count), 32'h00);

        do_reset();
        cycles(2);
        foreach (vecs[i]) begin
            press_release(vecs[i].mask);
            check({vecs[i].name, "_period"},  period, vecs[i].exp_period);
            check({vecs[i].name, "_running"}, 32'(running), 32'(vecs[i].exp_running));
            check({vecs[i].name, "_dir"},     32'(dir_down), 32'(vecs[i].exp_dir));
        end

        // Two-cycle glitch is rejected.
        tap(4'b0001, 2);
        cycles(15);
        check("glitch_period", period, 8);

        // Pause holds count and suppresses ticks; resume ticks one period later.
        tap(4'b0100, 6);
        wait_running("pause_running", 1'b0, 30);
        cycles(1);
        held  = count;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        check("pause_ticks", 32'(ticks), 0);
        check("pause_count", 32'(count), 32'(held));
        tap(4'b0100, 6);
        wait_running("resume_running", 1'b1, 30);
        wait_tick("resume_tick", 40, n);
        check("resume_latency", 32'(n), 8);
        check("resume_count", 32'(count), 32'(held + W_CNT'(1)));

        // Asynchronous reset mid-run with a key event still in flight.
        press_release(4'b1000);
        check("pre_reset_dir", 32'(dir_down), 1);
        key = 4'b0001;
        cycles(4);
        key = 4'b0000;
        cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count",   32'(count), 0);
        check("midrst_period",  period, 16);
        check("midrst_running", 32'(running), 1);
        check("midrst_dir",     32'(dir_down), 0);
        check("midrst_tick",    32'(tick), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        check("midrst_discarded", period, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
